// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants used by the
// resolution stage and the instruction queue.
package fetch_pkg;

  localparam int FETCH_W    = 10;
  localparam int DEC_W      = 2;
  localparam int TA_ENTRY_W = 35;

  typedef enum logic [2:0] {
    CT_NORMAL = 3'd0,
    CT_B      = 3'd1,
    CT_J      = 3'd2,
    CT_JALR   = 3'd3,
    CT_CALL   = 3'd4,
    CT_RET    = 3'd5
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  function automatic logic [31:0] slot_pc(
    input logic [31:0] base,
    input int          k
  );
    return base + 32'(k << 2);
  endfunction

endpackage

// File: rtl/fetch_inst_queue_slot_writer.sv
// Rotates the kept slots of a fetch packet onto the
// circular queue starting at tail.
module iq_slot_writer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       en,
  input  logic [$clog2(DEPTH)-1:0]   tail,
  input  logic [$clog2(FETCH_W+1)-1:0] n,
  input  logic [31:0]                base_pc,
  input  logic [FETCH_W*32-1:0]      packet,
  output logic [DEPTH-1:0]           we,
  output iq_entry_t [DEPTH-1:0]      wdata
);

  localparam int AW = $clog2(DEPTH);

  always_comb begin
    logic [AW-1:0] idx;
    we    = '0;
    wdata = '0;
    idx   = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      // pointer add wraps naturally since DEPTH is a power of two
      idx = tail + AW'(k);
      if (en && (k < int'(n))) begin
        we[idx]         = 1'b1;
        wdata[idx].pc   = slot_pc(base_pc, k);
        wdata[idx].inst = packet[k*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/fetch_inst_queue.sv
// Circular instruction queue between branch resolution
// and decode: packet-wide enqueue, up to DEC_W dequeue.
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_enqValid,
  output logic                       o_enqReady_1,
  input  logic [FETCH_W*32-1:0]      i_packetInst_320,
  input  logic [31:0]                i_packetPc_32,
  input  logic [7:0]                 i_cutPosition_8,
  output logic [DEC_W-1:0]           o_deqValid_2,
  output logic [DEC_W*32-1:0]        o_deqInst_64,
  output logic [DEC_W*32-1:0]        o_deqPc_64,
  input  logic [1:0]                 i_deqCount_2,
  output logic [$clog2(DEPTH):0]     o_count_5
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(FETCH_W + 1);

  iq_entry_t       mem [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic            fire;
  logic [NW-1:0]   n;
  logic [NW-1:0]   n_acc;
  logic [1:0]      d;
  logic [DEPTH-1:0] we;
  iq_entry_t [DEPTH-1:0] wdata;

  // ready looks only at the current count, never at this cycle's dequeue
  assign o_enqReady_1 = (count_q <= CW'(DEPTH - FETCH_W));
  assign fire  = i_enqValid && o_enqReady_1 && !i_flush;
  assign n_acc = fire ? n : '0;
  assign o_count_5 = count_q;

  always_comb begin
    if (i_cutPosition_8 >= 8'(FETCH_W))
      n = NW'(FETCH_W);
    else
      n = NW'(i_cutPosition_8) + NW'(1);
  end

  always_comb begin
    d = i_deqCount_2;
    if (d > 2'(DEC_W))
      d = 2'(DEC_W);
    if (CW'(d) > count_q)
      d = 2'(count_q);
  end

  always_comb begin
    iq_entry_t rd;
    rd = '0;
    o_deqValid_2 = '0;
    o_deqInst_64 = '0;
    o_deqPc_64   = '0;
    for (int k = 0; k < DEC_W; k++) begin
      rd = mem[head_q + AW'(k)];
      o_deqValid_2[k] = (count_q > CW'(k));
      if (o_deqValid_2[k]) begin
        o_deqInst_64[k*32 +: 32] = rd.inst;
        o_deqPc_64[k*32 +: 32]   = rd.pc;
      end
    end
  end

  iq_slot_writer #(
    .DEPTH   (DEPTH)
  ) u_writer (
    .en      (fire),
    .tail    (tail_q),
    .n       (n),
    .base_pc (i_packetPc_32),
    .packet  (i_packetInst_320),
    .we      (we),
    .wdata   (wdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++)
        mem[e] <= '0;
    end else if (i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(d);
      tail_q  <= tail_q + AW'(n_acc);
      count_q <= count_q + CW'(n_acc) - CW'(d);
      for (int e = 0; e < DEPTH; e++)
        if (we[e])
          mem[e] <= wdata[e];
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scenario bench for fetch_inst_queue with a
// queue scoreboard of expected {pc, inst} entries.
module tb_fetch_inst_queue;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_flush;
  logic         i_enqValid;
  logic         o_enqReady_1;
  logic [319:0] i_packetInst_320;
  logic [31:0]  i_packetPc_32;
  logic [7:0]   i_cutPosition_8;
  logic [1:0]   o_deqValid_2;
  logic [63:0]  o_deqInst_64;
  logic [63:0]  o_deqPc_64;
  logic [1:0]   i_deqCount_2;
  logic [4:0]   o_count_5;

  logic [63:0]  exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 i_clk = ~i_clk;

  fetch_inst_queue dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_flush          (i_flush),
    .i_enqValid       (i_enqValid),
    .o_enqReady_1     (o_enqReady_1),
    .i_packetInst_320 (i_packetInst_320),
    .i_packetPc_32    (i_packetPc_32),
    .i_cutPosition_8  (i_cutPosition_8),
    .o_deqValid_2     (o_deqValid_2),
    .o_deqInst_64     (o_deqInst_64),
    .o_deqPc_64       (o_deqPc_64),
    .i_deqCount_2     (i_deqCount_2),
    .o_count_5        (o_count_5)
  );

  task automatic idle();
    i_flush          = 1'b0;
    i_enqValid       = 1'b0;
    i_packetInst_320 = '0;
    i_packetPc_32    = '0;
    i_cutPosition_8  = '0;
    i_deqCount_2     = '0;
  endtask

  // one clock of stimulus; the scoreboard follows the queue contract
  task automatic drive(
    input bit          ev,
    input logic [31:0] pc,
    input logic [7:0]  cut,
    input logic [31:0] ibase,
    input logic [1:0]  dq,
    input bit          fl
  );
    int sz;
    int d;
    int n;
    bit rdy;
    i_enqValid      = ev;
    i_packetPc_32   = pc;
    i_cutPosition_8 = cut;
    for (int k = 0; k < 10; k++)
      i_packetInst_320[k*32 +: 32] = ibase + 32'(k);
    i_deqCount_2 = dq;
    i_flush      = fl;
    sz  = exp_q.size();
    rdy = (16 - sz) >= 10;
    @(posedge i_clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      d = (int'(dq) > 2) ? 2 : int'(dq);
      if (d > sz) d = sz;
      n = (cut >= 8'd10) ? 10 : int'(cut) + 1;
      repeat (d) void'(exp_q.pop_front());
      if (ev && rdy)
        for (int k = 0; k < n; k++)
          exp_q.push_back({pc + 32'(4 * k), ibase + 32'(k)});
    end
    #1;
    idle();
  endtask

  task automatic test_reset();
    n_cmp += 5;
    if (o_count_5 !== 5'd0) begin
      n_bad++; $display("FAIL rst_count got %0d want 0", o_count_5);
    end
    if (o_deqValid_2 !== 2'b00) begin
      n_bad++; $display("FAIL rst_valid got %b want 00", o_deqValid_2);
    end
    if (o_enqReady_1 !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got %b want 1", o_enqReady_1);
    end
    if (o_deqInst_64 !== 64'd0) begin
      n_bad++; $display("FAIL rst_inst got %h want 0", o_deqInst_64);
    end
    if (o_deqPc_64 !== 64'd0) begin
      n_bad++; $display("FAIL rst_pc got %h want 0", o_deqPc_64);
    end
  endtask

  task automatic test_full_packet();
    int guard;
    drive(1, 32'h1000, 8'd9, 32'hA0, 2'd0, 0);
    n_cmp += 3;
    if (o_count_5 !== 5'd10) begin
      n_bad++; $display("FAIL full_count got %0d want 10", o_count_5);
    end
    if (o_enqReady_1 !== 1'b0) begin
      n_bad++; $display("FAIL full_ready got %b want 0", o_enqReady_1);
    end
    if ({o_deqPc_64[31:0], o_deqInst_64[31:0]} !== 64'h00001000_000000A0) begin
      n_bad++; $display("FAIL full_slot0 got %h/%h want 1000/a0",
                        o_deqPc_64[31:0], o_deqInst_64[31:0]);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      for (int k = 0; k < 2; k++)
        if (k < exp_q.size()) begin
          n_cmp++;
          if ({o_deqPc_64[k*32 +: 32], o_deqInst_64[k*32 +: 32]} !== exp_q[k]) begin
            n_bad++; $display("FAIL full_drain%0d got %h/%h want %h", k,
                              o_deqPc_64[k*32 +: 32], o_deqInst_64[k*32 +: 32], exp_q[k]);
          end
        end
      drive(0, 0, 0, 0, 2'd2, 0);
      guard++;
    end
    n_cmp++;
    if (o_count_5 !== 5'd0 || o_deqValid_2 !== 2'b00) begin
      n_bad++; $display("FAIL full_empty got %0d/%b want 0/00", o_count_5, o_deqValid_2);
    end
  endtask

  task automatic test_cut_clamp();
    int guard;
    drive(1, 32'h3000, 8'd2, 32'h300, 2'd0, 0);
    n_cmp += 2;
    if (o_count_5 !== 5'd3) begin
      n_bad++; $display("FAIL cut2_count got %0d want 3", o_count_5);
    end
    if (exp_q[2][63:32] !== 32'h3008) begin
      n_bad++; $display("FAIL cut2_lastpc got %h want 3008", exp_q[2][63:32]);
    end
    drive(1, 32'h5000, 8'hFF, 32'h500, 2'd0, 0);
    n_cmp += 2;
    if (o_count_5 !== 5'd13) begin
      n_bad++; $display("FAIL cutff_count got %0d want 13", o_count_5);
    end
    if (o_enqReady_1 !== 1'b0) begin
      n_bad++; $display("FAIL cutff_ready got %b want 0", o_enqReady_1);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      n_cmp++;
      if (o_deqValid_2 !== {exp_q.size() > 1, exp_q.size() > 0}) begin
        n_bad++; $display("FAIL cut_valid got %b size %0d", o_deqValid_2, exp_q.size());
      end
      for (int k = 0; k < 2; k++)
        if (k < exp_q.size()) begin
          n_cmp++;
          if ({o_deqPc_64[k*32 +: 32], o_deqInst_64[k*32 +: 32]} !== exp_q[k]) begin
            n_bad++; $display("FAIL cut_drain%0d got %h/%h want %h", k,
                              o_deqPc_64[k*32 +: 32], o_deqInst_64[k*32 +: 32], exp_q[k]);
          end
        end
      drive(0, 0, 0, 0, 2'd2, 0);
      guard++;
    end
  endtask

  task automatic test_wrap();
    int guard;
    drive(0, 0, 0, 0, 2'd0, 1);
    drive(1, 32'h0100, 8'd9, 32'h10, 2'd0, 0);
    repeat (5) drive(0, 0, 0, 0, 2'd2, 0);
    drive(1, 32'h0200, 8'd1, 32'h20, 2'd0, 0);
    drive(0, 0, 0, 0, 2'd2, 0);
    n_cmp++;
    if (o_count_5 !== 5'd0) begin
      n_bad++; $display("FAIL wrap_pre got %0d want 0", o_count_5);
    end
    drive(1, 32'h2000, 8'd9, 32'hC0, 2'd0, 0);
    n_cmp += 2;
    if (o_count_5 !== 5'd10) begin
      n_bad++; $display("FAIL wrap_count got %0d want 10", o_count_5);
    end
    if (exp_q[7][63:32] !== 32'h201C) begin
      n_bad++; $display("FAIL wrap_idx3 got %h want 201c", exp_q[7][63:32]);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      for (int k = 0; k < 2; k++)
        if (k < exp_q.size()) begin
          n_cmp++;
          if ({o_deqPc_64[k*32 +: 32], o_deqInst_64[k*32 +: 32]} !== exp_q[k]) begin
            n_bad++; $display("FAIL wrap_drain%0d got %h/%h want %h", k,
                              o_deqPc_64[k*32 +: 32], o_deqInst_64[k*32 +: 32], exp_q[k]);
          end
        end
      drive(0, 0, 0, 0, 2'd2, 0);
      guard++;
    end
  endtask

  task automatic test_simul();
    drive(0, 0, 0, 0, 2'd0, 1);
    drive(1, 32'h6000, 8'd5, 32'h60, 2'd0, 0);
    n_cmp += 2;
    if (o_count_5 !== 5'd6) begin
      n_bad++; $display("FAIL simul_pre got %0d want 6", o_count_5);
    end
    if ({o_deqPc_64[63:32], o_deqInst_64[63:32]} !== exp_q[1]) begin
      n_bad++; $display("FAIL simul_slot1 got %h/%h want %h",
                        o_deqPc_64[63:32], o_deqInst_64[63:32], exp_q[1]);
    end
    drive(1, 32'h7000, 8'd3, 32'h70, 2'd2, 0);
    n_cmp += 2;
    if (o_count_5 !== 5'd8) begin
      n_bad++; $display("FAIL simul_count got %0d want 8", o_count_5);
    end
    if ({o_deqPc_64[31:0], o_deqInst_64[31:0]} !== exp_q[0]) begin
      n_bad++; $display("FAIL simul_head got %h/%h want %h",
                        o_deqPc_64[31:0], o_deqInst_64[31:0], exp_q[0]);
    end
    drive(1, 32'h8000, 8'd3, 32'h80, 2'd2, 1);
    n_cmp += 2;
    if (o_count_5 !== 5'd0) begin
      n_bad++; $display("FAIL flush_count got %0d want 0", o_count_5);
    end
    if (o_deqValid_2 !== 2'b00) begin
      n_bad++; $display("FAIL flush_valid got %b want 00", o_deqValid_2);
    end
  endtask

  task automatic test_over_deq();
    drive(1, 32'h4000, 8'd0, 32'h40, 2'd0, 0);
    n_cmp += 2;
    if (o_deqValid_2 !== 2'b01) begin
      n_bad++; $display("FAIL one_valid got %b want 01", o_deqValid_2);
    end
    if (o_deqInst_64[63:32] !== 32'd0 || o_deqPc_64[63:32] !== 32'd0) begin
      n_bad++; $display("FAIL one_slot1 got %h/%h want 0/0",
                        o_deqPc_64[63:32], o_deqInst_64[63:32]);
    end
    drive(0, 0, 0, 0, 2'd2, 0);
    n_cmp++;
    if (o_count_5 !== 5'd0 || o_deqValid_2 !== 2'b00) begin
      n_bad++; $display("FAIL over_count got %0d/%b want 0/00", o_count_5, o_deqValid_2);
    end
    drive(1, 32'h4100, 8'd4, 32'h41, 2'd0, 0);
    drive(0, 0, 0, 0, 2'd3, 0);
    n_cmp += 2;
    if (o_count_5 !== 5'd3) begin
      n_bad++; $display("FAIL dq3_count got %0d want 3", o_count_5);
    end
    if ({o_deqPc_64[31:0], o_deqInst_64[31:0]} !== exp_q[0]) begin
      n_bad++; $display("FAIL dq3_head got %h/%h want %h",
                        o_deqPc_64[31:0], o_deqInst_64[31:0], exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h9000, 8'd9, 32'h90, 2'd0, 0);
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle();
    i_rst_n = 1'b0;
    #12;
    test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    test_full_packet();
    test_cut_clamp();
    test_wrap();
    test_simul();
    test_over_deq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Instruction queue directly downstream of the branch/jump resolution stage.
- Accepts one fetch packet per cycle: 10 instruction slots, the packet base PC, and the cut position that stage produces (index of the last slot kept before a taken control transfer).
- Buffers the kept instructions with their PCs in a circular queue.
- Hands up to 2 instructions per cycle to decode, in program order.
- Supports a full flush on redirect.

Parameters:
- DEPTH, 16, queue entries; power of two, must be >= FETCH_W + DEC_W.
- FETCH_W, 10, instruction slots per fetch packet.
- DEC_W, 2, maximum instructions dequeued per cycle.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  discard all queued contents.
- i_enqValid  in  1  fetch packet present.
- o_enqReady_1  out  1  queue can accept a full packet this cycle.
- i_packetInst_320  in  FETCH_W*32  slot k instruction at bits [k*32 +: 32].
- i_packetPc_32  in  32  PC of slot 0.
- i_cutPosition_8  in  8  last kept slot index.
- o_deqValid_2  out  DEC_W  bit k set when output slot k holds a valid instruction.
- o_deqInst_64  out  DEC_W*32  instruction at head+k.
- o_deqPc_64  out  DEC_W*32  PC at head+k.
- i_deqCount_2  in  2  number of instructions decode consumes this cycle (0..DEC_W).
- o_count_5  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - Entry array of DEPTH × {pc[31:0], inst[31:0]}.
  - Head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count, log2(DEPTH)+1 bits.
- Reset (asynchronous, i_rst_n low):
  - head = tail = count = 0; array cleared to 0.
  - o_enqReady_1 = 1, o_deqValid_2 = 0, o_deqInst_64 = 0, o_deqPc_64 = 0, o_count_5 = 0.
  - Reset asserted mid-operation discards everything immediately.
- o_enqReady_1:
  - Combinational: (DEPTH - count) >= FETCH_W.
  - Independent of same-cycle dequeue, so there is no ready-from-deq path.
- Enqueue:
  - Fires when i_enqValid && o_enqReady_1 && !i_flush.
  - Kept count n = i_cutPosition_8 + 1, clamped to FETCH_W when i_cutPosition_8 >= FETCH_W.
  - For k in 0..n-1, entry[(tail+k) mod DEPTH] = {i_packetPc_32 + 4*k, slot k}; 32-bit PC arithmetic wraps.
  - tail += n.
  - Slots beyond n are dropped.
  - i_enqValid while not ready is ignored; upstream holds the packet.
- Dequeue:
  - o_deqValid_2[k] = (count > k).
  - Output k reads entry[(head+k) mod DEPTH] combinationally from registered state.
  - Invalid output slots drive 0.
  - Effective d = min(i_deqCount_2, count, DEC_W); illegal requests are clamped, never underflow.
  - head += d.
- Count update: count_next = count + n_accepted - d; enqueue and dequeue in the same cycle are both applied.
- Latency and ordering:
  - An instruction enqueued at edge N is visible on the outputs after edge N, with no same-cycle bypass.
  - Program order is preserved across packets and across pointer wrap.
- Flush:
  - Highest priority: at the edge where i_flush = 1, head = tail = count = 0.
  - Same-cycle enqueue and dequeue are discarded.
  - Array contents need not be cleared.
  - o_enqReady_1 stays computed from the current count during the flush cycle.
- Full/empty:
  - Empty: all deqValid bits are 0 and d = 0.
  - Overflow is impossible by construction, since ready guarantees FETCH_W free entries.

Decomposition:
- Shared package fetch_pkg:
  - FETCH_W and DEC_W constants.
  - Control-type encodings shared with the resolution stage (NORMAL=0, B=1, J=2, JALR=3, CALL=4, RET=5).
  - Type-and-address entry width of 35.
  - iq_entry_t struct {pc, inst}.
- One natural sub-module, iq_slot_writer:
  - Given tail, n, base PC and the packet, produces per-entry write-enable and write-data vectors for the DEPTH array.
  - Keeps the rotate/wrap logic isolated and separately testable.

Test Plan:
- Reset mid-stream: enqueue 10, assert i_rst_n=0 -> same cycle o_count_5=0, o_deqValid_2=00, o_enqReady_1=1.
- Full packet: i_packetPc_32=0x1000, cut=9, inst k=0xA0+k -> next cycle count=10, deq slot0 {0x1000,0xA0}, slot1 {0x1004,0xA1}, ready=0 (free 6).
- Cut and clamp: cut=2 -> count +3, last entry PC base+8; cut=0xFF -> count +10.
- Wrap-around: advance head/tail to 12 via enq/deq, enqueue cut=9 base 0x2000 -> entry at index 3 holds PC 0x201C; dequeue order continuous 0x2000, 0x2004, ...
- Simultaneous enq/deq/flush:
  - count=6, enq cut=3, i_deqCount_2=2 -> count=8.
  - Repeat with i_flush=1 -> count=0, deqValid=00.
- Over-dequeue: count=1, i_deqCount_2=2 -> count=0, head advances by 1, no underflow.
